// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_pkg: shared state encoding, FP op codes and result constants for the FPU issue controller
package fpu_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ABORT} state_t;
  localparam logic [4:0] FADD = 5'b10000;
  localparam logic [4:0] FSUB = 5'b10001;
  localparam logic [4:0] FMUL = 5'b10010;
  localparam logic [4:0] FDIV = 5'b10011;
  localparam logic [4:0] FSQRT = 5'b11011;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: issue/completion handshake between the EX-stage controller and the FPU
interface fpu_issue_ctrl_if;
  logic fpu_start;
  logic [4:0] fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic fpu_done;
  logic [31:0] fpu_result;
  modport master (output fpu_start, fpu_op, fpu_a, fpu_b, input fpu_done, fpu_result);
  modport slave (input fpu_start, fpu_op, fpu_a, fpu_b, output fpu_done, fpu_result);
endinterface

// File: rtl/fpu_issue_ctrl_watchdog.sv
// fpu_watchdog: 4-bit cycle counter that flags when MAX_LAT enabled cycles have elapsed
module fpu_watchdog #(
  parameter int MAX_LAT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [3:0] LIM = 4'(MAX_LAT - 1);
  logic [3:0] cnt;
  // expiry fires during the MAX_LAT-th enabled cycle so the FSM leaves on the next edge
  assign expired = enable & (cnt == LIM);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + 4'd1 : cnt;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: EX-stage initiator that issues FP ops to the multi-cycle FPU and stalls until completion
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int MAX_LAT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic [4:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  fpu_issue_ctrl_if.master fpu,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] fp_result_ex,
  output logic        busy,
  output logic        timeout_err
);
  state_t state;
  logic fp_op, trigger, wd_en, expired;
  assign fp_op = ex_valid & alu_control[4];
  assign trigger = fp_op & ~flush;
  assign wd_en = (state == WAIT) | (state == ABORT);
  assign busy = state != IDLE;
  // while draining an aborted op, only a new FP op has to wait; other instructions flow
  assign stall = ((state == IDLE) & trigger) | (state == ISSUE) | (state == WAIT) | ((state == ABORT) & fp_op);
  fpu_watchdog #(.MAX_LAT(MAX_LAT)) u_wd (
    .clk(clk),
    .rstn(rstn),
    .clear(~wd_en),
    .enable(wd_en),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      fpu.fpu_start <= 1'b0;
      fpu.fpu_op <= '0;
      fpu.fpu_a <= '0;
      fpu.fpu_b <= '0;
      result_valid <= 1'b0;
      fp_result_ex <= '0;
      timeout_err <= 1'b0;
    end else begin
      fpu.fpu_start <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: if (trigger) begin
          state <= ISSUE;
          fpu.fpu_start <= 1'b1;
          fpu.fpu_op <= alu_control;
          fpu.fpu_a <= src_a;
          fpu.fpu_b <= src_b;
        end
        ISSUE: state <= flush ? ABORT : WAIT;
        WAIT: if (fpu.fpu_done) begin
          state <= flush ? IDLE : DONE;
          result_valid <= ~flush;
          fp_result_ex <= flush ? fp_result_ex : fpu.fpu_result;
        end else if (flush) begin
          state <= ABORT;
        end else if (expired) begin
          state <= DONE;
          result_valid <= 1'b1;
          fp_result_ex <= CANON_NAN;
          timeout_err <= 1'b1;
        end
        DONE: state <= IDLE;
        ABORT: if (fpu.fpu_done) begin
          state <= IDLE;
        end else if (expired) begin
          state <= IDLE;
          timeout_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of issue timing, flush/abort, watchdog and reset behaviour
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;
  logic clk = 1'b0, rstn = 1'b0, ex_valid = 1'b0, wd_ex_valid = 1'b0, flush = 1'b0;
  logic [4:0] alu_control = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic stall, result_valid, busy, timeout_err;
  logic [31:0] fp_result_ex;
  logic w_stall, w_rv, w_busy, w_terr;
  logic [31:0] w_res;
  int n_chk = 0, n_err = 0;
  fpu_issue_ctrl_if f();
  fpu_issue_ctrl_if fw();
  fpu_issue_ctrl dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .flush(flush), .fpu(f.master),
    .stall(stall), .result_valid(result_valid), .fp_result_ex(fp_result_ex),
    .busy(busy), .timeout_err(timeout_err)
  );
  fpu_issue_ctrl #(.MAX_LAT(4)) dut_wd (
    .clk(clk), .rstn(rstn), .ex_valid(wd_ex_valid), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .flush(1'b0), .fpu(fw.master),
    .stall(w_stall), .result_valid(w_rv), .fp_result_ex(w_res),
    .busy(w_busy), .timeout_err(w_terr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    f.fpu_done = 1'b0;
    f.fpu_result = '0;
    fw.fpu_done = 1'b0;
    fw.fpu_result = '0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_start", f.fpu_start, 0);
    check("rst_op", f.fpu_op, 0);
    check("rst_a", f.fpu_a, 0);
    check("rst_rv", result_valid, 0);
    check("rst_res", fp_result_ex, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    // fadd with the fastest possible FPU
    ex_valid = 1'b1; alu_control = FADD; src_a = 32'h3F80_0000; src_b = 32'h4000_0000;
    #1;
    check("add_t0_stall", stall, 1);
    check("add_t0_start", f.fpu_start, 0);
    tick; #1;
    check("add_t1_start", f.fpu_start, 1);
    check("add_t1_op", f.fpu_op, FADD);
    check("add_t1_a", f.fpu_a, 32'h3F80_0000);
    check("add_t1_b", f.fpu_b, 32'h4000_0000);
    check("add_t1_stall", stall, 1);
    tick;
    f.fpu_done = 1'b1; f.fpu_result = 32'h4040_0000;
    #1;
    check("add_t2_start", f.fpu_start, 0);
    check("add_t2_stall", stall, 1);
    tick;
    f.fpu_done = 1'b0; ex_valid = 1'b0;
    #1;
    check("add_t3_rv", result_valid, 1);
    check("add_t3_res", fp_result_ex, 32'h4040_0000);
    check("add_t3_stall", stall, 0);
    tick; #1;
    check("add_t4_rv", result_valid, 0);
    check("add_t4_busy", busy, 0);
    check("add_t4_res", fp_result_ex, 32'h4040_0000);
    // fdiv with a slow FPU answering at T9
    ex_valid = 1'b1; alu_control = FDIV; src_a = 32'h40A0_0000; src_b = 32'h4000_0000;
    #1;
    check("div_t0_stall", stall, 1);
    for (int k = 1; k <= 9; k++) begin
      tick;
      f.fpu_done = (k == 9); f.fpu_result = 32'h4020_0000;
      #1;
      check("div_start", f.fpu_start, 32'(k == 1));
      check("div_stall", stall, 1);
      check("div_rv", result_valid, 0);
      check("div_a", f.fpu_a, 32'h40A0_0000);
      check("div_b", f.fpu_b, 32'h4000_0000);
    end
    tick;
    f.fpu_done = 1'b0; ex_valid = 1'b0;
    #1;
    check("div_t10_rv", result_valid, 1);
    check("div_t10_res", fp_result_ex, 32'h4020_0000);
    check("div_t10_stall", stall, 0);
    tick; #1;
    check("div_t11_rv", result_valid, 0);
    // flush at T4, late FPU answer at T7, non-FP op sits in EX from T5
    ex_valid = 1'b1; alu_control = FMUL; src_a = 32'h4100_0000; src_b = 32'h4110_0000;
    for (int k = 1; k <= 8; k++) begin
      tick;
      flush = (k == 4);
      if (k == 5) alu_control = 5'b00010;
      f.fpu_done = (k == 7); f.fpu_result = 32'hDEAD_BEEF;
      #1;
      check("fl_stall", stall, 32'(k < 5));
      check("fl_rv", result_valid, 0);
      check("fl_busy", busy, 32'(k < 8));
    end
    check("fl_res_held", fp_result_ex, 32'h4020_0000);
    ex_valid = 1'b0;
    // watchdog on the MAX_LAT=4 instance, FPU never answers
    wd_ex_valid = 1'b1; alu_control = FSQRT; src_a = 32'h4080_0000;
    #1;
    check("wd_t0_stall", w_stall, 1);
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k == 6) wd_ex_valid = 1'b0;
      #1;
      check("wd_rv", w_rv, 32'(k == 6));
      check("wd_terr", w_terr, 32'(k >= 6));
      check("wd_busy", w_busy, 32'(k <= 6));
      if (k == 6) check("wd_nan", w_res, CANON_NAN);
    end
    check("wd_main_terr", timeout_err, 0);
    // fmul then fsub back-to-back, each answered two cycles after issue
    ex_valid = 1'b1; alu_control = FMUL; src_a = 32'h3FC0_0000; src_b = 32'h4000_0000;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 4) begin
        alu_control = FSUB; src_a = 32'h4080_0000; src_b = 32'h3F80_0000;
      end
      f.fpu_done = (k == 3) || (k == 8);
      f.fpu_result = (k == 3) ? 32'h4040_0000 : 32'h4040_0001;
      #1;
      check("b2b_start", f.fpu_start, 32'(k == 1 || k == 6));
      check("b2b_rv", result_valid, 32'(k == 4 || k == 9));
      if (k == 1) check("b2b_op1", f.fpu_op, FMUL);
      if (k == 4) check("b2b_res1", fp_result_ex, 32'h4040_0000);
      if (k == 6) check("b2b_op2", f.fpu_op, FSUB);
      if (k == 6) check("b2b_a2", f.fpu_a, 32'h4080_0000);
      if (k == 9) check("b2b_res2", fp_result_ex, 32'h4040_0001);
    end
    // third op reaches WAIT, then reset drops mid-operation
    for (int k = 10; k <= 12; k++) begin
      tick;
      f.fpu_done = 1'b0;
    end
    #1;
    check("rs_busy_before", busy, 1);
    rstn = 1'b0; ex_valid = 1'b0;
    #1;
    check("rs_stall", stall, 0);
    check("rs_start", f.fpu_start, 0);
    check("rs_op", f.fpu_op, 0);
    check("rs_a", f.fpu_a, 0);
    check("rs_b", f.fpu_b, 0);
    check("rs_rv", result_valid, 0);
    check("rs_res", fp_result_ex, 0);
    check("rs_busy", busy, 0);
    check("rs_terr", timeout_err, 0);
    tick;
    rstn = 1'b1; f.fpu_done = 1'b1; f.fpu_result = 32'h1234_5678;
    tick;
    f.fpu_done = 1'b0;
    #1;
    check("late_busy", busy, 0);
    check("late_rv", result_valid, 0);
    check("late_res", fp_result_ex, 0);
    check("late_start", f.fpu_start, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

EX-stage initiator for the multi-cycle floating-point unit. It detects FP operations (`alu_control[4]==1`) arriving from the ALU controller and latches their operands. It then issues a one-cycle start to the FPU, stalls the pipeline until the unit reports completion, and presents the registered result to EX for writeback. It also handles pipeline flushes and an FPU that never responds.

## Interface

Parameters:
- `MAX_LAT`, default 15: watchdog limit, in cycles spent in WAIT without `fpu_done`. Range 1–15; the counter is 4 bits.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `ex_valid`, in, 1: EX holds a valid instruction.
- `alu_control`, in, 5: from `alu_controller`. Bit 4 set means FP op. Encodings: `10000` fadd, `10001` fsub, `10010` fmul, `10011` fdiv, `11011` fsqrt.
- `src_a`, in, 32: EX operand A.
- `src_b`, in, 32: EX operand B.
- `flush`, in, 1: squash the instruction in EX.
- `fpu_start`, out, 1: one-cycle issue pulse.
- `fpu_op`, out, 5: latched `alu_control`.
- `fpu_a`, out, 32: latched `src_a`.
- `fpu_b`, out, 32: latched `src_b`.
- `fpu_done`, in, 1: FPU result valid (single-cycle pulse).
- `fpu_result`, in, 32: FPU result, valid with `fpu_done`.
- `stall`, out, 1: freeze IF/ID/EX.
- `result_valid`, out, 1: one-cycle pulse; `fp_result_ex` is valid.
- `fp_result_ex`, out, 32: registered FP result.
- `busy`, out, 1: state is not IDLE.
- `timeout_err`, out, 1: sticky watchdog flag.

## Operation

States and transitions:
- **IDLE**
  - Trigger is `ex_valid & alu_control[4] & ~flush`.
  - On trigger: latch op and operands, then go to ISSUE.
- **ISSUE** (one cycle)
  - `fpu_start=1`; go to WAIT.
  - `fpu_done` is ignored here.
  - With `flush`: go to ABORT. The start pulse still fires, so the FPU must be drained.
- **WAIT**
  - The watchdog counter increments each cycle.
  - On `fpu_done`: capture `fpu_result`, go to DONE.
  - On `flush` without `fpu_done`: go to ABORT.
  - If `fpu_done` and `flush` arrive together: discard the result, go to IDLE.
  - If the counter reaches `MAX_LAT` without `fpu_done`:
    - set `timeout_err`;
    - load `fp_result_ex` with 32'h7FC00000 (canonical NaN);
    - go to DONE.
- **DONE** (one cycle)
  - `result_valid=1`, `stall=0`; the pipeline advances.
  - Go to IDLE.
  - No retrigger from DONE, so the completing instruction is never issued twice.
- **ABORT**
  - Wait for `fpu_done`, discard its result, go to IDLE.
  - `stall` is asserted only while a new FP op waits in EX (`ex_valid & alu_control[4]`).
  - Non-FP instructions proceed.
  - The watchdog runs here too. On expiry: set `timeout_err`, go to IDLE.

Stall rules:
- `stall` is combinational: `(state==IDLE & trigger) | state==ISSUE | state==WAIT | (state==ABORT & ex_valid & alu_control[4])`.
- Non-FP ops (`alu_control[4]==0`) never cause a stall in IDLE.
- `fp_result_ex` holds its value until the next capture.
- `timeout_err` clears only on reset.

## Timing

- All outputs reset to 0; state resets to IDLE; the counter resets to 0.
- Reset mid-operation: return to IDLE immediately and drop all pending work.
- Per-operation timeline:
  - T0: trigger in IDLE; `stall=1`.
  - T1: ISSUE; `fpu_start=1`, operands stable.
  - T2 onward: WAIT.
  - If `fpu_done` is sampled at Tk (k≥2), DONE is at Tk+1 with `result_valid=1`.
  - Stall cycles = k+1. The minimum is 3 (`fpu_done` at T2).
- `fpu_op`, `fpu_a` and `fpu_b` are held constant from T1 until the FSM returns to IDLE.
- Back-to-back FP ops: DONE at Tn, IDLE at Tn+1; a second FP op triggers at Tn+1.
- Watchdog: with no `fpu_done`, DONE is reached at T(2+`MAX_LAT`).

## Structure

- Package `fpu_pkg`:
  - state enum: IDLE, ISSUE, WAIT, DONE, ABORT;
  - FP op code constants (FADD, FSUB, FMUL, FDIV, FSQRT);
  - `CANON_NAN`.
- Sub-module `fpu_watchdog`: 4-bit counter with `clear`, `enable` and `expired` against `MAX_LAT`.
- FSM, operand latches and stall logic stay in the top module.

## Test plan

- **fadd, fast FPU.** `alu_control=10000`, `src_a=3F800000`, `src_b=40000000`, `fpu_done` at T2 with 40400000. Expect `fpu_start` only at T1, `stall` at T0–T2, and at T3 `result_valid=1` with `fp_result_ex=40400000`.
- **fdiv, slow FPU.** `fpu_done` at T9. Expect `stall` high T0–T9, `result_valid` at T10 only, and `fpu_a`/`fpu_b` constant throughout.
- **Flush during WAIT.** Assert `flush` at T4; `fpu_done` at T7; a non-FP op is in EX. Expect `stall=0` from T5, no `result_valid`, `busy` low at T8.
- **Watchdog.** `MAX_LAT=4`, `fpu_done` never asserted. Expect DONE at T6 with `fp_result_ex=7FC00000` and `timeout_err=1` persisting after completion.
- **Back-to-back, then reset.** fmul then fsub, each answered after 2 cycles: two distinct `fpu_start` pulses, the second at DONE+2. Then drop `rstn` during a later WAIT: all outputs 0 at once, state IDLE, and a late `fpu_done` is ignored.
